fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/pc_incr.sv | 12 +
 rtl/fetch_unit.sv | 151 +++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, datapath width and reset vector.
`timescale 1ns/1ps
package cpu_pkg;

   localparam int          CPU_XLEN     = 32;
   localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_HOLD  = 2'b10,
      ST_DRAIN = 2'b11
   } fetch_state_t;

   // A memory request is live in FETCH and DRAIN.
   function automatic logic is_req_state(input fetch_state_t st);
      return (st == ST_FETCH) || (st == ST_DRAIN);
   endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential PC increment: adds one 4-byte instruction, wrapping at the top of the address space.
`timescale 1ns/1ps
module pc_incr #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
);

   assign pc_plus4 = pc + {{(XLEN-3){1'b0}}, 3'b100};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time and presents the
// returned instruction downstream, with stall hold and branch redirect.
`timescale 1ns/1ps
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int             XLEN     = CPU_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(CPU_RESET_PC)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] branch_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_data_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   fetch_state_t    state;
   fetch_state_t    next_state;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_q_next;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] addr_next;
   logic [XLEN-1:0] pc_out_next;
   logic [XLEN-1:0] instr_next;
   logic            valid_next;
   logic            req_next;
   logic            accept;
   logic            load_addr;

   pc_incr #(
      .XLEN     (XLEN)
   ) u_pc_incr (
      .pc       (pc_q),
      .pc_plus4 (pc_plus4)
   );

   assign target = branch_pc_i & ~{{(XLEN-2){1'b0}}, 2'b11};

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; a redirect always wins over a stall.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (flush_i) begin
               next_state = ST_IDLE;
            end else if (start_i) begin
               next_state = ST_FETCH;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (flush_i) begin
               next_state = imem_ack_i ? ST_FETCH : ST_DRAIN;
            end else if (imem_ack_i) begin
               next_state = ST_HOLD;
            end else begin
               next_state = ST_FETCH;
            end
         end
         ST_HOLD: begin
            if (flush_i) begin
               next_state = ST_FETCH;
            end else if (stall_i) begin
               next_state = ST_HOLD;
            end else begin
               next_state = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (imem_ack_i) begin
               next_state = ST_FETCH;
            end else begin
               next_state = ST_DRAIN;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered datapath and outputs.
   always_comb begin
      pc_q_next   = pc_q;
      pc_out_next = pc_o;
      instr_next  = instr_o;
      valid_next  = valid_o;
      accept      = (state == ST_FETCH) && imem_ack_i && !flush_i;
      if (flush_i) begin
         pc_q_next  = target;
         valid_next = 1'b0;
      end else if (accept) begin
         pc_q_next   = pc_plus4;
         pc_out_next = imem_addr_o;
         instr_next  = imem_data_i;
         valid_next  = 1'b1;
      end else if ((state == ST_HOLD) && !stall_i) begin
         valid_next = 1'b0;
      end else begin
         valid_next = valid_o;
      end

      // Address reloads only when a new request starts, never mid-request.
      load_addr = (next_state == ST_FETCH) && ((state != ST_FETCH) || imem_ack_i);
      if (load_addr) begin
         addr_next = pc_q_next;
      end else begin
         addr_next = imem_addr_o;
      end
      req_next = is_req_state(next_state);
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pc_q        <= RESET_PC;
         imem_req_o  <= 1'b0;
         imem_addr_o <= RESET_PC;
         pc_o        <= {XLEN{1'b0}};
         instr_o     <= {XLEN{1'b0}};
         valid_o     <= 1'b0;
      end else begin
         pc_q        <= pc_q_next;
         imem_req_o  <= req_next;
         imem_addr_o <= addr_next;
         pc_o        <= pc_out_next;
         instr_o     <= instr_next;
         valid_o     <= valid_next;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a scoreboard of expected (pc, instr) deliveries.
`timescale 1ns/1ps
module tb_fetch_unit;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        stall;
   logic        flush;
   logic [31:0] branch_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] pc_out;
   logic [31:0] instr;
   logic        valid;
   logic        auto_ack;
   logic        man_ack;
   logic        use_nop;

   logic        start2;
   logic        req2;
   logic [31:0] addr2;
   logic [31:0] pc2;
   logic [31:0] instr2;
   logic        valid2;

   int          n_checks = 0;
   int          n_fail   = 0;
   fetch_t      exp_q[$];
   logic        prev_valid = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_ack  = auto_ack ? imem_req : man_ack;
   assign imem_data = use_nop ? 32'h0000_0013 : mem_word(imem_addr);

   fetch_unit dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .stall_i     (stall),
      .flush_i     (flush),
      .branch_pc_i (branch_pc),
      .imem_req_o  (imem_req),
      .imem_addr_o (imem_addr),
      .imem_ack_i  (imem_ack),
      .imem_data_i (imem_data),
      .pc_o        (pc_out),
      .instr_o     (instr),
      .valid_o     (valid)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start2),
      .stall_i     (1'b0),
      .flush_i     (1'b0),
      .branch_pc_i (32'h0000_0000),
      .imem_req_o  (req2),
      .imem_addr_o (addr2),
      .imem_ack_i  (req2),
      .imem_data_i (32'h0000_0013),
      .pc_o        (pc2),
      .instr_o     (instr2),
      .valid_o     (valid2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Called while a request to a is outstanding: expect delivery, pulse ack.
   task automatic fetch_ok(input logic [31:0] a);
      check32("req_addr", imem_addr, a);
      exp_q.push_back({a, mem_word(a)});
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
   endtask

   // Each new valid_o rise must match the oldest expected delivery.
   always @(negedge clk) begin
      fetch_t e;
      if (rst && valid && !prev_valid) begin
         check1("sb_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check32("sb_pc", pc_out, e.pc);
            check32("sb_instr", instr, e.instr);
         end
      end
      prev_valid = valid;
   end

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; branch_pc = 32'h0;
      auto_ack = 1'b1; man_ack = 1'b0; use_nop = 1'b1; start2 = 1'b0;
      #2 rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check1("rst_req", imem_req, 1'b0);
      check32("rst_addr", imem_addr, 32'h0);
      check32("rst_pc", pc_out, 32'h0);
      check32("rst_instr", instr, 32'h0);
      check1("rst_valid", valid, 1'b0);
      check32("rst_addr2", addr2, 32'hFFFF_FFFC);
      check1("rst_req2", req2, 1'b0);

      // Zero-wait streaming: valid every second cycle, pc 0,4,8.
      exp_q.push_back({32'h0, 32'h13});
      exp_q.push_back({32'h4, 32'h13});
      exp_q.push_back({32'h8, 32'h13});
      rst = 1'b1; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check1("seq_valid", valid, (i % 2) == 1);
         check1("seq_req", imem_req, (i % 2) == 0);
         if ((i % 2) == 0) check32("seq_addr", imem_addr, 32'(4 * (i / 2)));
      end

      // Stall in HOLD at pc 8.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check32("stall_pc", pc_out, 32'h8);
         check32("stall_instr", instr, 32'h13);
         check1("stall_valid", valid, 1'b1);
         check1("stall_req", imem_req, 1'b0);
      end
      stall = 1'b0; auto_ack = 1'b0; use_nop = 1'b0;
      @(negedge clk);
      check1("c_req", imem_req, 1'b1);
      fetch_ok(32'hC);

      // Flush while the request to 0x10 is outstanding; ack two cycles later.
      @(negedge clk);
      check32("f10_addr", imem_addr, 32'h10);
      flush = 1'b1; branch_pc = 32'h40;
      @(negedge clk);
      flush = 1'b0;
      check1("drain_req", imem_req, 1'b1);
      check32("drain_addr", imem_addr, 32'h10);
      check1("drain_valid", valid, 1'b0);
      @(negedge clk);
      check32("drain_addr2", imem_addr, 32'h10);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      check32("redir_addr", imem_addr, 32'h40);
      check1("redir_req", imem_req, 1'b1);
      check1("redir_valid", valid, 1'b0);
      fetch_ok(32'h40);

      // Flush beats stall in HOLD; low bits of the target are dropped.
      flush = 1'b1; stall = 1'b1; branch_pc = 32'h103;
      @(negedge clk);
      flush = 1'b0; stall = 1'b0;
      check1("fs_valid", valid, 1'b0);
      check1("fs_req", imem_req, 1'b1);
      fetch_ok(32'h100);

      // Flush coincident with ack in FETCH drops the data.
      @(negedge clk);
      check32("fa_addr", imem_addr, 32'h104);
      flush = 1'b1; branch_pc = 32'h200; man_ack = 1'b1;
      @(negedge clk);
      flush = 1'b0; man_ack = 1'b0;
      check1("fa_valid", valid, 1'b0);
      check1("fa_req", imem_req, 1'b1);
      fetch_ok(32'h200);

      // Stray ack in HOLD is ignored.
      stall = 1'b1; man_ack = 1'b1;
      @(negedge clk);
      stall = 1'b0; man_ack = 1'b0;
      check32("hack_pc", pc_out, 32'h200);
      check32("hack_instr", instr, mem_word(32'h200));
      check1("hack_req", imem_req, 1'b0);

      // Second flush while draining retargets without disturbing the old request.
      @(negedge clk);
      check32("dd_addr", imem_addr, 32'h204);
      flush = 1'b1; branch_pc = 32'h300;
      @(negedge clk);
      branch_pc = 32'h380;
      @(negedge clk);
      flush = 1'b0;
      check32("dd_hold_addr", imem_addr, 32'h204);
      check1("dd_req", imem_req, 1'b1);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      fetch_ok(32'h380);

      // Reset mid-request, then a stray ack after release.
      @(negedge clk);
      check1("mr_req", imem_req, 1'b1);
      rst = 1'b0; start = 1'b0;
      #1;
      check1("ar_req", imem_req, 1'b0);
      check32("ar_addr", imem_addr, 32'h0);
      check32("ar_pc", pc_out, 32'h0);
      check32("ar_instr", instr, 32'h0);
      check1("ar_valid", valid, 1'b0);
      @(negedge clk);
      rst = 1'b1; man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      check1("stray_req", imem_req, 1'b0);
      check1("stray_valid", valid, 1'b0);

      // Flush in IDLE stays idle but sets the next fetch address.
      flush = 1'b1; branch_pc = 32'h502;
      @(negedge clk);
      flush = 1'b0;
      check1("if_req", imem_req, 1'b0);
      start = 1'b1;
      @(negedge clk);
      check1("if_go_req", imem_req, 1'b1);
      fetch_ok(32'h500);
      start = 1'b0;

      // Wrap of the PC from the top of the address space.
      start2 = 1'b1;
      for (int i = 0; i < 10 && !valid2; i++) @(negedge clk);
      check1("wrap_valid", valid2, 1'b1);
      check32("wrap_pc", pc2, 32'hFFFF_FFFC);
      check32("wrap_instr", instr2, 32'h13);
      @(negedge clk);
      check32("wrap_next_addr", addr2, 32'h0);
      check1("wrap_next_req", req2, 1'b1);

      check32("sb_drained", exp_q.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
